// File: rtl/asi_rw_arb_pkg.sv
// Shared types and constants for the AXI-slave user-side read/write arbiter.
package asi_rw_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_st_t;

  localparam int ARB_PRI_WRITE = 0;
  localparam int ARB_PRI_READ  = 1;

endpackage

// File: rtl/asi_rw_arb_if.sv
// Request/beat/grant handshake between the write and read engines and the arbiter.
interface asi_rw_arb_if;

  logic usr_wrequest;
  logic usr_we;
  logic usr_wlast;
  logic usr_wgrant;
  logic usr_rrequest;
  logic usr_re;
  logic usr_rlast;
  logic usr_rgrant;

  modport master (
    output usr_wrequest, usr_we, usr_wlast,
    output usr_rrequest, usr_re, usr_rlast,
    input  usr_wgrant, usr_rgrant
  );

  modport slave (
    input  usr_wrequest, usr_we, usr_wlast,
    input  usr_rrequest, usr_re, usr_rlast,
    output usr_wgrant, usr_rgrant
  );

endinterface

// File: rtl/asi_rw_arb.sv
// Burst-atomic fixed-priority arbiter sharing the user memory port between the
// write and read engines, with a bounded-streak guard for the lower-priority side.
module asi_rw_arb
  import asi_rw_arb_pkg::*;
#(
  parameter int ASI_ARB  = ARB_PRI_WRITE,
  parameter int ARB_MAXW = 4,
  parameter int ARB_CW   = (ARB_MAXW < 1) ? 1 : $clog2(ARB_MAXW + 1)
) (
  input  logic              usr_clk,
  input  logic              usr_reset_n,
  asi_rw_arb_if.slave       bus,
  output logic [ARB_CW-1:0] arb_streak,
  output logic              arb_err
);

  localparam logic PREF_RD = (ASI_ARB == ARB_PRI_READ) ? 1'b1 : 1'b0;
  localparam logic [ARB_CW-1:0] STREAK_MAX = '1;
  localparam logic [ARB_CW-1:0] STREAK_ONE = ARB_CW'(1);

  arb_st_t           state;
  arb_st_t           state_nxt;
  logic              last_rd;
  logic              last_rd_nxt;
  logic [ARB_CW-1:0] streak_nxt;
  logic              w_end;
  logic              r_end;
  logic              burst_end;
  logic              other_req;
  logic              bad_beat;

  // Picks the next owner; the streak and last owner passed in already reflect
  // any burst finishing this cycle, so the override takes effect immediately.
  function automatic arb_st_t pick(input logic              wreq,
                                   input logic              rreq,
                                   input logic [ARB_CW-1:0] streak,
                                   input logic              last_r);
    logic take_rd;
    if (!wreq && !rreq) return ARB_IDLE;
    if (wreq && !rreq)  return ARB_WR;
    if (!wreq && rreq)  return ARB_RD;
    take_rd = PREF_RD;
    if ((ARB_MAXW != 0) && (32'(streak) >= 32'(ARB_MAXW)) && (last_r == PREF_RD))
      take_rd = !PREF_RD;
    return take_rd ? ARB_RD : ARB_WR;
  endfunction

  assign w_end     = (state == ARB_WR) && bus.usr_we && bus.usr_wlast;
  assign r_end     = (state == ARB_RD) && bus.usr_re && bus.usr_rlast;
  assign burst_end = w_end || r_end;
  assign other_req = r_end ? bus.usr_wrequest : bus.usr_rrequest;
  assign bad_beat  = (bus.usr_we && (state != ARB_WR)) || (bus.usr_re && (state != ARB_RD));

  always_comb begin
    streak_nxt  = arb_streak;
    last_rd_nxt = last_rd;
    state_nxt   = state;
    if (burst_end) begin
      last_rd_nxt = r_end;
      if (!other_req)
        streak_nxt = '0;
      else if (last_rd == r_end)
        streak_nxt = (arb_streak == STREAK_MAX) ? arb_streak : arb_streak + 1'b1;
      else
        streak_nxt = STREAK_ONE;
    end
    if ((state == ARB_IDLE) || burst_end)
      state_nxt = pick(bus.usr_wrequest, bus.usr_rrequest, streak_nxt, last_rd_nxt);
  end

  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state          <= ARB_IDLE;
      bus.usr_wgrant <= 1'b0;
      bus.usr_rgrant <= 1'b0;
      arb_streak     <= '0;
      last_rd        <= 1'b0;
      arb_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.usr_wgrant <= (state_nxt == ARB_WR);
      bus.usr_rgrant <= (state_nxt == ARB_RD);
      arb_streak     <= streak_nxt;
      last_rd        <= last_rd_nxt;
      if (bad_beat)
        arb_err <= 1'b1;
    end
  end

endmodule
